pll_lock_sequencer: RTL and testbench
=====================================

// Module: pll_lock_sequencer
// PURPOSE
//  - Power-up/relock controller for the system PLL (50 MHz ref -> 2x 100 MHz outputs).
//  - Clocked from the free-running PLL reference clock, because the PLL output clocks are invalid until lock.
//  - Pulses PLL reset, waits for a debounced lock, then releases the downstream system reset.
//  - Retries on lock timeout, flags a fault after MAX_RETRIES, and re-sequences on loss of lock or on software request.
// PARAMETERS
//  RST_HOLD_CYCLES      16     refclk cycles pll_rst is held high per attempt (>=1)
//  LOCK_TIMEOUT_CYCLES  50000  max cycles in WAIT_LOCK before a retry (1 ms @ 50 MHz)
//  LOCK_STABLE_CYCLES   1024   consecutive synced-lock cycles required before RUN (>=1)
//  MAX_RETRIES          3      timeouts tolerated before FAULT; RETRY_W = $clog2(MAX_RETRIES+1)
// PORTS
//  refclk         in   1        reference clock, 50 MHz; the only clock
//  rst            in   1        synchronous reset, active-high
//  pll_locked     in   1        PLL lock, asynchronous to refclk
//  relock_req     in   1        single-cycle request to restart the sequence (synchronous)
//  pll_rst        out  1        reset to the PLL
//  sys_rst        out  1        reset request to the 100 MHz domain; that domain synchronises it
//  ready          out  1        high only in RUN
//  fault          out  1        high only in FAULT
//  retry_cnt      out  RETRY_W  lock timeouts in the current sequence
//  lock_loss_cnt  out  8        loss-of-lock events seen in RUN (see CONFIGURATION)
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values (rst=1): state=RST_HOLD, pll_rst=1, sys_rst=1, ready=0, fault=0, retry_cnt=0, lock_loss_cnt=0, all counters 0.
//  - pll_locked passes through a 2-flop synchroniser, giving locked_s 2 cycles later. The FSM uses only locked_s.
//  - One shared cycle counter (cnt) is cleared on every state change. Its width is the $clog2 of the largest count parameter.
//  - RST_HOLD: pll_rst=1, sys_rst=1.
//    - When cnt==RST_HOLD_CYCLES-1, go to WAIT_LOCK.
//    - pll_rst deasserts on the cycle WAIT_LOCK is entered.
//  - WAIT_LOCK: pll_rst=0, sys_rst=1.
//    - locked_s=1: go to STABLE.
//    - Otherwise, when cnt==LOCK_TIMEOUT_CYCLES-1:
//      - retry_cnt==MAX_RETRIES: go to FAULT.
//      - Otherwise: retry_cnt+1, go to RST_HOLD.
//  - STABLE: sys_rst=1.
//    - locked_s=0: go back to WAIT_LOCK. Timeout restarts; retry_cnt is unchanged.
//    - When cnt==LOCK_STABLE_CYCLES-1 with locked_s=1: go to RUN.
//    - sys_rst=0 and ready=1 on the first RUN cycle.
//  - RUN: sys_rst=0, ready=1.
//    - locked_s=0: go to RST_HOLD with retry_cnt cleared. This is a new event, not a retry.
//    - On the next cycle sys_rst=1, ready=0, pll_rst=1.
//  - FAULT: pll_rst=1, sys_rst=1, fault=1.
//    - Exits only on rst or relock_req.
//  - relock_req in any state: go to RST_HOLD and clear retry_cnt and cnt.
//    - Takes priority over every lock/timeout transition in the same cycle.
//    - relock_req in RST_HOLD restarts the hold count.
//  - A lock glitch shorter than 2 cycles may be missed by design. A glitch seen in STABLE restarts debounce.
//  - rst mid-sequence aborts immediately; the next cycle shows the reset values.
//  - retry_cnt saturates at MAX_RETRIES, so it never wraps.
//  - Illegal state encoding: go to RST_HOLD.
// CONFIGURATION
//  - Macro PLL_SEQ_LOCK_LOSS_CNT_EN.
//  - Defined:
//    - lock_loss_cnt increments by 1 on each RUN->RST_HOLD transition caused by locked_s=0. It does not count relock_req.
//    - Saturates at 255.
//    - Cleared only by rst.
//  - Undefined:
//    - Counter logic is removed; lock_loss_cnt is tied to 8'd0.
//    - All other behaviour is identical.
// STRUCTURE
//  - Package pll_seq_pkg:
//    - state enum {RST_HOLD, WAIT_LOCK, STABLE, RUN, FAULT}, 3-bit encoding.
//    - LOSS_CNT_W=8.
//    - Function cnt_width(a,b,c) returning $clog2 of the max.
//  - Sub-module pll_lock_sync: 2-flop synchroniser for pll_locked.
//    - Reset value 0 under rst.
//    - Synthesis keep / false-path on flop 1.
//  - Top level: FSM, shared counter, retry counter, optional loss counter.
// TESTING
//  Bench parameters: RST_HOLD=4, TIMEOUT=20, STABLE=8, MAX_RETRIES=2.
//  1. Reset then pll_locked=1 at cycle 10:
//     - pll_rst falls at cycle 4.
//     - ready rises at cycle 10+2+8.
//     - sys_rst=0 on that same cycle.
//  2. pll_locked held 0:
//     - 2 retries (retry_cnt 1, 2), then FAULT at cycle 3*(4+20).
//     - fault=1, pll_rst=1.
//     - relock_req then clears fault and retry_cnt and restarts the sequence.
//  3. 1-cycle-late drop of lock during STABLE (count 5):
//     - Returns to WAIT_LOCK.
//     - ready is delayed by a full new 8-cycle debounce.
//     - retry_cnt is unchanged.
//  4. pll_locked falls in RUN:
//     - 3 cycles later ready=0, sys_rst=1, pll_rst=1.
//     - lock_loss_cnt=1 when the macro is defined, 0 when it is not.
//  5. relock_req in the same cycle as a WAIT_LOCK timeout:
//     - Goes to RST_HOLD with retry_cnt=0, not retry_cnt+1.
//  6. rst asserted in STABLE:
//     - Next cycle all outputs show reset values.
//     - 300 forced RUN loss events give lock_loss_cnt=255 (saturation).

Source files
------------

// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared types and helpers for the PLL lock sequencer.
//   pll_state_e : sequencer FSM states (3-bit encoding)
//   LOSS_CNT_W  : width of the loss-of-lock event counter
//   cnt_width() : width of the shared cycle counter
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RST_HOLD  = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_e;

  localparam int LOSS_CNT_W = 8;

  // $clog2 of the largest of the three counts, never below 1 bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: 2-flop synchroniser bringing pll_locked into the refclk domain.
//   clk_i   : refclk
//   rst_i   : synchronous reset, active-high (both flops clear to 0)
//   async_i : asynchronous lock input
//   sync_o  : synchronised lock, two cycles behind async_i
module pll_lock_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o
);

  // First stage may go metastable; keep it and exclude it from timing.
  (* ASYNC_REG = "TRUE", keep = "true", false_path = "true" *) logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: power-up / relock controller for the system PLL.
// Runs from the free-running reference clock. Pulses the PLL reset, waits for
// a debounced lock, then releases the downstream system reset. Retries on lock
// timeout, faults after MAX_RETRIES, re-sequences on lock loss or relock_req.
// Ports:
//   refclk_i         : reference clock (only clock)
//   rst_i            : synchronous reset, active-high
//   pll_locked_i     : PLL lock, asynchronous
//   relock_req_i     : single-cycle restart request
//   pll_rst_o        : reset to the PLL
//   sys_rst_o        : reset request to the 100 MHz domain
//   ready_o          : high only in RUN
//   fault_o          : high only in FAULT
//   retry_cnt_o      : lock timeouts in the current sequence
//   lock_loss_cnt_o  : loss-of-lock events seen in RUN
// Build option: define PLL_SEQ_LOCK_LOSS_CNT_EN to enable the loss counter;
// otherwise lock_loss_cnt_o is tied to zero.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES     = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 3,
  localparam int RETRY_W = $clog2(MAX_RETRIES + 1)
) (
  input  logic                  refclk_i,
  input  logic                  rst_i,
  input  logic                  pll_locked_i,
  input  logic                  relock_req_i,
  output logic                  pll_rst_o,
  output logic                  sys_rst_o,
  output logic                  ready_o,
  output logic                  fault_o,
  output logic [RETRY_W-1:0]    retry_cnt_o,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt_o
);

  localparam int CNT_W = cnt_width(int'(RST_HOLD_CYCLES), int'(LOCK_TIMEOUT_CYCLES),
                                   int'(LOCK_STABLE_CYCLES));
  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TMO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  logic locked_s;

  pll_lock_sync u_sync (
    .clk_i   (refclk_i),
    .rst_i   (rst_i),
    .async_i (pll_locked_i),
    .sync_o  (locked_s)
  );

  pll_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               pll_rst_q, pll_rst_d;
  logic               sys_rst_q, sys_rst_d;
  logic               ready_q, ready_d;
  logic               fault_q, fault_d;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    if (relock_req_i) begin
      // Software restart wins over any lock/timeout decision this cycle.
      state_d = RST_HOLD;
      retry_d = '0;
    end else begin
      case (state_q)
        RST_HOLD: begin
          if (cnt_q == HOLD_LAST) state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_d = STABLE;
          end else if (cnt_q == TMO_LAST) begin
            if (retry_q == RETRY_MAX) begin
              state_d = FAULT;
            end else begin
              state_d = RST_HOLD;
              retry_d = retry_q + RETRY_W'(1);
            end
          end
        end
        STABLE: begin
          // A dropout restarts the wait (and its timeout) without a retry.
          if (!locked_s)              state_d = WAIT_LOCK;
          else if (cnt_q == STB_LAST) state_d = RUN;
        end
        RUN: begin
          // Lock loss in RUN is a fresh sequence, not a retry.
          if (!locked_s) begin
            state_d = RST_HOLD;
            retry_d = '0;
          end
        end
        FAULT:   state_d = FAULT;
        default: state_d = RST_HOLD;
      endcase
    end

    // Shared counter: cleared on any state change or restart; idle in RUN/FAULT.
    cnt_d = cnt_q;
    if (relock_req_i || (state_d != state_q))
      cnt_d = '0;
    else if (state_q == RST_HOLD || state_q == WAIT_LOCK || state_q == STABLE)
      cnt_d = cnt_q + CNT_W'(1);

    // Outputs are decoded from the next state so they change with the state.
    pll_rst_d = (state_d == RST_HOLD) || (state_d == FAULT);
    sys_rst_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
    fault_d   = (state_d == FAULT);
  end

  always_ff @(posedge refclk_i) begin
    if (rst_i) begin
      state_q   <= RST_HOLD;
      cnt_q     <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  assign pll_rst_o   = pll_rst_q;
  assign sys_rst_o   = sys_rst_q;
  assign ready_o     = ready_q;
  assign fault_o     = fault_q;
  assign retry_cnt_o = retry_q;

`ifdef PLL_SEQ_LOCK_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;

  // Only lock-driven exits from RUN count; relock_req takes priority.
  always_comb begin
    loss_d = loss_q;
    if (state_q == RUN && !relock_req_i && !locked_s && loss_q != '1)
      loss_d = loss_q + LOSS_CNT_W'(1);
  end

  always_ff @(posedge refclk_i) begin
    if (rst_i) loss_q <= '0;
    else       loss_q <= loss_d;
  end

  assign lock_loss_cnt_o = loss_q;
`else
  assign lock_loss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with RST_HOLD=4, TIMEOUT=20,
// STABLE=8, MAX_RETRIES=2. Inputs are driven and outputs sampled 1 ns after
// each rising edge; "edge n" below counts edges from the last reset edge.
module tb_pll_lock_sequencer;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst, sys_rst, ready, fault;
  logic [1:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  int n_vec  = 0;
  int n_miss = 0;

`ifdef PLL_SEQ_LOCK_LOSS_CNT_EN
  localparam int LOSS_EN = 1;
`else
  localparam int LOSS_EN = 0;
`endif

  always #10 refclk = ~refclk;

  pll_lock_sequencer #(
    .RST_HOLD_CYCLES     (4),
    .LOCK_TIMEOUT_CYCLES (20),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRIES         (2)
  ) dut (
    .refclk_i        (refclk),
    .rst_i           (rst),
    .pll_locked_i    (pll_locked),
    .relock_req_i    (relock_req),
    .pll_rst_o       (pll_rst),
    .sys_rst_o       (sys_rst),
    .ready_o         (ready),
    .fault_o         (fault),
    .retry_cnt_o     (retry_cnt),
    .lock_loss_cnt_o (lock_loss_cnt)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for ready to reach v; an expired bound shows up as a miscompare.
  task automatic wait_ready(input logic v);
    int k;
    k = 0;
    while (ready !== v && k < 64) begin
      tick(1);
      k++;
    end
    chk("wait_ready", 32'(ready), 32'(v));
  endtask

  initial begin
    // Reset state
    tick(3);
    chk("rst_pll_rst", 32'(pll_rst), 1);
    chk("rst_sys_rst", 32'(sys_rst), 1);
    chk("rst_ready",   32'(ready), 0);
    chk("rst_fault",   32'(fault), 0);
    chk("rst_retry",   32'(retry_cnt), 0);
    chk("rst_loss",    32'(lock_loss_cnt), 0);
    rst = 1'b0;

    // 1: lock seen at edge 10 -> pll_rst falls at 4, ready at 20
    tick(3);  chk("t1_pll_rst_e3", 32'(pll_rst), 1);
    tick(1);  chk("t1_pll_rst_e4", 32'(pll_rst), 0);
              chk("t1_sys_rst_e4", 32'(sys_rst), 1);
    tick(5);  pll_locked = 1'b1;
    tick(10); chk("t1_ready_e19", 32'(ready), 0);
              chk("t1_sysrst_e19", 32'(sys_rst), 1);
    tick(1);  chk("t1_ready_e20", 32'(ready), 1);
              chk("t1_sysrst_e20", 32'(sys_rst), 0);
              chk("t1_pllrst_e20", 32'(pll_rst), 0);

    // 4: lock drops in RUN -> outputs fall back 3 edges later
    pll_locked = 1'b0;
    tick(2);  chk("t4_ready_e22", 32'(ready), 1);
    tick(1);  chk("t4_ready_e23", 32'(ready), 0);
              chk("t4_sysrst",    32'(sys_rst), 1);
              chk("t4_pllrst",    32'(pll_rst), 1);
              chk("t4_retry",     32'(retry_cnt), 0);
              chk("t4_loss",      32'(lock_loss_cnt), 32'(LOSS_EN));

    // 2: no lock -> retries at +24, +48, FAULT at +72
    tick(23); chk("t2_retry_23",  32'(retry_cnt), 0);
              chk("t2_pllrst_23", 32'(pll_rst), 0);
    tick(1);  chk("t2_retry_24",  32'(retry_cnt), 1);
              chk("t2_pllrst_24", 32'(pll_rst), 1);
    tick(24); chk("t2_retry_48",  32'(retry_cnt), 2);
    tick(23); chk("t2_fault_71",  32'(fault), 0);
    tick(1);  chk("t2_fault_72",  32'(fault), 1);
              chk("t2_pllrst_72", 32'(pll_rst), 1);
              chk("t2_sysrst_72", 32'(sys_rst), 1);
              chk("t2_ready_72",  32'(ready), 0);
              chk("t2_retry_72",  32'(retry_cnt), 2);
    tick(5);  chk("t2_fault_hold", 32'(fault), 1);
              chk("t2_retry_sat",  32'(retry_cnt), 2);
    relock_req = 1'b1;
    tick(1);  relock_req = 1'b0;
              chk("t2_relock_fault", 32'(fault), 0);
              chk("t2_relock_retry", 32'(retry_cnt), 0);
              chk("t2_relock_pll",   32'(pll_rst), 1);

    // 5: relock_req coincident with a WAIT_LOCK timeout
    tick(24); chk("t5_retry_24",  32'(retry_cnt), 1);
    tick(23); chk("t5_pllrst_47", 32'(pll_rst), 0);
    relock_req = 1'b1;
    tick(1);  relock_req = 1'b0;
              chk("t5_retry_48",  32'(retry_cnt), 0);
              chk("t5_pllrst_48", 32'(pll_rst), 1);
    // relock_req in RST_HOLD restarts the 4-cycle hold
    tick(2);  relock_req = 1'b1;
    tick(1);  relock_req = 1'b0;
    tick(3);  chk("t5_hold_restart", 32'(pll_rst), 1);
    tick(1);  chk("t5_hold_done",    32'(pll_rst), 0);

    // 3: 1-cycle lock glitch while STABLE count is 5 -> fresh debounce
    pll_locked = 1'b1;
    tick(6);  chk("t3_ready_w6", 32'(ready), 0);
    pll_locked = 1'b0;
    tick(1);  pll_locked = 1'b1;
    tick(4);  chk("t3_ready_w11", 32'(ready), 0);
    tick(6);  chk("t3_ready_w17", 32'(ready), 0);
    tick(1);  chk("t3_ready_w18", 32'(ready), 1);
              chk("t3_sysrst",    32'(sys_rst), 0);
              chk("t3_retry",     32'(retry_cnt), 0);

    // 6: relock from RUN (not a loss event), then rst while STABLE
    relock_req = 1'b1;
    tick(1);  relock_req = 1'b0;
              chk("t6_relock_ready", 32'(ready), 0);
              chk("t6_relock_loss",  32'(lock_loss_cnt), 32'(LOSS_EN));
    tick(6);  chk("t6_stable_pll", 32'(pll_rst), 0);
              chk("t6_stable_sys", 32'(sys_rst), 1);
    rst = 1'b1;
    tick(1);  rst = 1'b0;
              chk("t6_rst_pll",   32'(pll_rst), 1);
              chk("t6_rst_sys",   32'(sys_rst), 1);
              chk("t6_rst_ready", 32'(ready), 0);
              chk("t6_rst_fault", 32'(fault), 0);
              chk("t6_rst_retry", 32'(retry_cnt), 0);
              chk("t6_rst_loss",  32'(lock_loss_cnt), 0);
    tick(3);  chk("t6_hold_e3", 32'(pll_rst), 1);
    tick(1);  chk("t6_hold_e4", 32'(pll_rst), 0);

    // 300 lock-loss events from RUN -> counter saturates at 255
    for (int i = 0; i < 300; i++) begin
      wait_ready(1'b1);
      pll_locked = 1'b0;
      wait_ready(1'b0);
      pll_locked = 1'b1;
    end
    chk("t6_loss_sat", 32'(lock_loss_cnt), 32'(LOSS_EN * 255));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
